flag_cond_unit: RTL
===================

# flag_cond_unit

Condition-flag register and predication stage that consumes the Neg/Z/C/V flags produced by the execute-stage ALU. It holds the architectural NZCV register, evaluates each instruction's 4-bit condition code against it, and updates NZCV when a flag-setting instruction executes. It emits a registered execute-enable to the write-back stage and supports one-deep flag save/restore for exception entry and return.

## Interface
Parameters:
- N, 4: ALU data width; only passed through to the result register.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  instruction present in execute stage.
- cond  in  4  condition code of that instruction.
- set_flags  in  1  instruction requests NZCV update (S bit).
- alu_result  in  N  ALU result for this instruction.
- Neg, Z, C, V  in  1 each  ALU flags for this instruction, same cycle.
- stall  in  1  hold all state this cycle.
- flush  in  1  kill the instruction in execute this cycle.
- save_flags  in  1  copy NZCV to shadow (exception entry).
- restore_flags  in  1  copy shadow to NZCV (exception return).
- valid_out  out  1  registered: instruction reached write-back.
- exec_en  out  1  registered: condition passed; write-back may commit.
- result_out  out  N  registered alu_result.
- nzcv  out  4  architectural flags {N,Z,C,V}, MSB = N.

## Operation
- Condition pass, evaluated on the current nzcv (the pre-update value):
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C&!Z. LS 1001: !C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: !Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. NV 1111: 0 (reserved, never executes).
- accept = valid_in & !stall & !flush.
- Flag update: nzcv <= {Neg,Z,C,V} when accept & set_flags & pass. A failed condition never updates flags.
- Per-edge priority, highest first:
  - reset;
  - restore_flags (nzcv <= shadow; overrides any ALU update in the same cycle);
  - stall (nzcv, shadow and output regs hold; save/restore are ignored while stalled);
  - flush / normal.
- save_flags & !stall: shadow <= the nzcv value before this edge's update.
- save_flags and restore_flags together: nzcv <= old shadow and shadow <= old nzcv (swap).
- Output stage, when !stall:
  - valid_out <= valid_in & !flush;
  - exec_en <= valid_in & !flush & pass;
  - result_out <= alu_result.
- exec_en is never 1 while valid_out is 0.

## Timing
- Reset values: nzcv = 4'b0000, shadow = 4'b0000, valid_out = 0, exec_en = 0, result_out = 0.
- Latency: 1 cycle from valid_in to valid_out/exec_en.
- nzcv changes on the same edge that registers the instruction. The instruction in execute in the next cycle sees the new flags, so back-to-back flag-dependent instructions need no bubble.
- A flush arriving with stall = 0 inserts a bubble (valid_out = 0 next cycle) and blocks the flag update.
- A flush arriving with stall = 1 has no effect that cycle; the pipeline controller holds flush until stall drops.
- Reset asserted mid-operation clears all state immediately, without waiting for clk.
- No combinational path from any input to any output. nzcv is a direct register output.

## Structure
- Package cond_pkg holds:
  - cond_e enum (16 codes above);
  - flag bit-index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
- Sub-module cond_eval is purely combinational: cond + nzcv -> pass. The instruction decoder reuses it for branch prediction.
- flag_cond_unit contains only the registers and priority logic.

## Test plan
- Reset, then drive valid_in = 1, cond = AL, set_flags = 1, Neg = 0, Z = 1, C = 1, V = 0 -> next cycle valid_out = 1, exec_en = 1, nzcv = 4'b0110.
- With nzcv = 4'b0110, send cond = NE with set_flags = 1 and ALU flags 4'b1000 -> exec_en = 0 and nzcv stays 4'b0110. Then send cond = EQ -> exec_en = 1.
- Sweep all 16 cond values against all 16 nzcv values -> exec_en matches the table. NV always 0, AL always 1 (256 checks).
- Hold stall = 1 for 3 cycles with valid_in = 1, set_flags = 1 -> outputs and nzcv frozen. Assert flush with stall = 0 -> valid_out = 0, exec_en = 0, nzcv unchanged.
- With nzcv = 4'b1001:
  - assert save_flags, then set flags to 4'b0100 -> shadow = 4'b1001;
  - assert restore_flags in the same cycle as an AL set_flags instruction with ALU flags 4'b0010 -> nzcv = 4'b1001 (restore wins), and that instruction's exec_en = 1.
- Assert rst_n low between clock edges while valid_out = 1 and nzcv = 4'b1111 -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/flag_cond_unit_pkg.sv
// Shared definitions for the condition-flag unit: condition-code encoding
// and the bit positions of each flag inside the packed NZCV vector.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/flag_cond_unit_if.sv
// Execute-stage to write-back bundle for the condition-flag unit.
// The master side (pipeline control / execute) drives the instruction and
// control strobes; the slave side (flag_cond_unit) returns registered results.
interface flag_cond_unit_if #(
    parameter int N = 4
);
    logic         valid_in;
    logic [3:0]   cond;
    logic         set_flags;
    logic [N-1:0] alu_result;
    logic         Neg;
    logic         Z;
    logic         C;
    logic         V;
    logic         stall;
    logic         flush;
    logic         save_flags;
    logic         restore_flags;
    logic         valid_out;
    logic         exec_en;
    logic [N-1:0] result_out;
    logic [3:0]   nzcv;

    modport master (
        output valid_in, cond, set_flags, alu_result, Neg, Z, C, V,
               stall, flush, save_flags, restore_flags,
        input  valid_out, exec_en, result_out, nzcv
    );

    modport slave (
        input  valid_in, cond, set_flags, alu_result, Neg, Z, C, V,
               stall, flush, save_flags, restore_flags,
        output valid_out, exec_en, result_out, nzcv
    );
endinterface

// File: rtl/flag_cond_unit_cond_eval.sv
// Purely combinational condition evaluator: decides whether an instruction
// with the given condition code executes under the supplied NZCV flags.
// Kept standalone so the decoder can reuse it for branch prediction.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic f_n;
    logic f_z;
    logic f_c;
    logic f_v;

    assign f_n = nzcv[FLAG_N];
    assign f_z = nzcv[FLAG_Z];
    assign f_c = nzcv[FLAG_C];
    assign f_v = nzcv[FLAG_V];

    // Condition table lookup; NV is reserved and never executes.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            COND_EQ: pass = f_z;
            COND_NE: pass = ~f_z;
            COND_CS: pass = f_c;
            COND_CC: pass = ~f_c;
            COND_MI: pass = f_n;
            COND_PL: pass = ~f_n;
            COND_VS: pass = f_v;
            COND_VC: pass = ~f_v;
            COND_HI: pass = f_c & ~f_z;
            COND_LS: pass = ~f_c | f_z;
            COND_GE: pass = (f_n == f_v);
            COND_LT: pass = (f_n != f_v);
            COND_GT: pass = ~f_z & (f_n == f_v);
            COND_LE: pass = f_z | (f_n != f_v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Architectural NZCV register with predication and one-deep save/restore.
// The condition is evaluated on the flags held before this edge, so an
// instruction's own flag update is visible to the next instruction with no
// bubble. Stall freezes everything, including save/restore requests.
module flag_cond_unit
    import cond_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flag_cond_unit_if.slave      bus
);

    logic         pass;
    logic         accept;

    logic [3:0]   nzcv_d,       nzcv_q;
    logic [3:0]   shadow_d,     shadow_q;
    logic         valid_out_d,  valid_out_q;
    logic         exec_en_d,    exec_en_q;
    logic [N-1:0] result_out_d, result_out_q;

    cond_eval u_cond_eval (
        .cond (bus.cond),
        .nzcv (nzcv_q),
        .pass (pass)
    );

    assign accept = bus.valid_in & ~bus.stall & ~bus.flush;

    // Next-state: stall holds all state; restore beats the ALU update;
    // save captures the pre-edge flags, so save+restore swaps the two.
    always_comb begin
        nzcv_d       = nzcv_q;
        shadow_d     = shadow_q;
        valid_out_d  = valid_out_q;
        exec_en_d    = exec_en_q;
        result_out_d = result_out_q;

        if (!bus.stall) begin
            if (bus.restore_flags) begin
                nzcv_d = shadow_q;
            end else if (accept && bus.set_flags && pass) begin
                nzcv_d = {bus.Neg, bus.Z, bus.C, bus.V};
            end

            if (bus.save_flags) begin
                shadow_d = nzcv_q;
            end

            valid_out_d  = bus.valid_in & ~bus.flush;
            exec_en_d    = bus.valid_in & ~bus.flush & pass;
            result_out_d = bus.alu_result;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_q       <= 4'b0000;
            shadow_q     <= 4'b0000;
            valid_out_q  <= 1'b0;
            exec_en_q    <= 1'b0;
            result_out_q <= '0;
        end else begin
            nzcv_q       <= nzcv_d;
            shadow_q     <= shadow_d;
            valid_out_q  <= valid_out_d;
            exec_en_q    <= exec_en_d;
            result_out_q <= result_out_d;
        end
    end

    assign bus.nzcv       = nzcv_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.exec_en    = exec_en_q;
    assign bus.result_out = result_out_q;

endmodule
